rr_arb2_sel: RTL and testbench
==============================

Name: rr_arb2_sel

Overview:
- Two-requester round-robin arbiter that generates the select line and one-hot grant for the 2:1 data mux directly downstream; `sel` connects straight to the mux select input `s`.
- Holds a grant while the winner keeps requesting, bounded by a maximum hold time, so neither source starves.
- Fully synchronous outputs; sits between the two data sources' request logic and the 2:1 mux.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles a grant is held while the other requester waits; legal range >= 1.
- CNT_W, $clog2(MAX_HOLD+1): hold counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  2  request per source; req[i] high = source i wants the mux
- grant  output  2  one-hot registered grant; 2'b00 when idle
- sel  output  1  mux select; equals index of current/last grantee
- busy  output  1  high when grant != 2'b00
- hold_cnt  output  CNT_W  cycles current grant has been held, saturating at MAX_HOLD

Behaviour:
- Reset (async assert, sync release): state IDLE, grant=2'b00, sel=0, busy=0, hold_cnt=0, priority pointer ptr=0 (source 0 favoured).
- States: IDLE, G0, G1. Outputs are registered and decoded from the state: grant=2'b01 in G0, 2'b10 in G1.
- Latency: a request sampled on edge N produces grant at edge N+1 (one cycle). No combinational req->grant path.
- IDLE:
  - req=00 -> stay IDLE.
  - req=01 -> G0.
  - req=10 -> G1.
  - req=11 -> G[ptr].
- Gi (other source is j):
  - req[i]=0 and req[j]=1 -> Gj.
  - req[i]=0 and req[j]=0 -> IDLE.
  - req[i]=1, req[j]=1 and hold_cnt==MAX_HOLD-1 -> Gj (forced rotation after exactly MAX_HOLD grant cycles).
  - Otherwise stay in Gi.
- hold_cnt:
  - Loads 0 on every state entry (including a switch Gi->Gj).
  - Increments each cycle spent in Gi, saturating at MAX_HOLD.
  - Is 0 in IDLE.
  - With no competing request, the grant continues indefinitely and hold_cnt saturates without wrap.
- ptr:
  - On leaving Gi (to IDLE or Gj), ptr <= j.
  - Unchanged otherwise.
  - Ensures a simultaneous request after an idle gap goes to the source not served last.
- sel:
  - Updates with the grant: 0 in G0, 1 in G1.
  - Holds its last value in IDLE, so the mux output does not glitch between bursts.
- busy = |grant.
- Grant is never 2'b11. Grant never switches mid-cycle. Switching G0->G1 takes one edge with no idle bubble.
- Reset asserted mid-grant: all outputs go to reset values immediately (asynchronously). First post-release arbitration behaves as from IDLE with ptr=0.
- MAX_HOLD=1: rotation occurs every cycle when both sources request continuously (strict alternation).
- Req X/Z is not handled; the bench must drive known values.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, G0, G1}, 2-bit encoding.
  - GRANT_NONE=2'b00, GRANT0=2'b01, GRANT1=2'b10.
- One sub-module: hold_counter.
  - Parameters MAX_HOLD and CNT_W.
  - Ports: clk, rst_n, clr, en, cnt, at_limit.
  - at_limit = (cnt==MAX_HOLD-1).
  - Saturating up-counter with synchronous clear.
- The top level holds the FSM, ptr and output registers.

Test Plan:
- Reset check: hold rst_n=0 with req=11 for 3 cycles -> grant=00, sel=0, busy=0, hold_cnt=0. Drop rst_n mid-grant later -> outputs go to reset values within the same timestep, not at the next edge.
- Single requester: req=10 from IDLE -> grant=10, sel=1, busy=1 one edge later. Hold req=10 for 10 cycles -> grant stays 10, hold_cnt saturates at 4. Set req=00 -> IDLE next edge, sel stays 1.
- Simultaneous requests after reset: req=11 -> G0 (ptr=0). With MAX_HOLD=4, grant=01 for exactly 4 cycles, then 10 for 4 cycles, then 01 (alternating bursts of 4 while req=11 held).
- Early release: in G0 with req=11, drop req[0] at hold_cnt=1 -> grant=10 next edge with no 00 bubble, hold_cnt restarts at 0.
- Pointer fairness: serve G1 alone, go IDLE for 2 cycles, then req=11 -> grant=01 (ptr=0). Serve G0 alone, go IDLE, then req=11 -> grant=10.
- MAX_HOLD=1 instance, req=11 held for 6 cycles -> grant sequence 01,10,01,10,01,10; grant never 11 (assertion on every cycle).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and grant encodings for the two-requester round-robin arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT0     = 2'b01;
  localparam logic [1:0] GRANT1     = 2'b10;

endpackage

// File: rtl/hold_counter.sv
// Saturating hold-time counter with synchronous clear; at_limit flags the
// last cycle a contested grant may be kept.
module hold_counter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] SAT  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_limit = (cnt_q == LAST);

endmodule

// File: rtl/rr_arb2_sel.sv
// Two-requester round-robin arbiter driving a 2:1 mux select, with bounded
// grant hold so a continuously requesting winner cannot starve the other side.
module rr_arb2_sel
  import arb_pkg::*;
#(
  parameter  int unsigned MAX_HOLD = 4,
  localparam int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  output logic [1:0]       grant,
  output logic             sel,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  state_e state_q, state_d;
  logic   ptr_q, ptr_d;
  logic   sel_q, sel_d;
  logic   cnt_clr;
  logic   at_limit;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        unique case (req)
          2'b01:   state_d = G0;
          2'b10:   state_d = G1;
          2'b11:   state_d = ptr_q ? G1 : G0;
          default: state_d = IDLE;
        endcase
      end
      G0: begin
        if (!req[0])                 state_d = req[1] ? G1 : IDLE;
        else if (req[1] && at_limit) state_d = G1;
      end
      G1: begin
        if (!req[1])                 state_d = req[0] ? G0 : IDLE;
        else if (req[0] && at_limit) state_d = G0;
      end
      default: state_d = IDLE;
    endcase

    // Leaving a grant hands priority to the other source for the next tie.
    if (state_q == G0 && state_d != G0) ptr_d = 1'b1;
    if (state_q == G1 && state_d != G1) ptr_d = 1'b0;

    if (state_d == G0) sel_d = 1'b0;
    if (state_d == G1) sel_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  assign cnt_clr = (state_d != state_q) || (state_d == IDLE);

  hold_counter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (1'b1),
    .cnt      (hold_cnt),
    .at_limit (at_limit)
  );

  always_comb begin
    unique case (state_q)
      G0:      grant = GRANT0;
      G1:      grant = GRANT1;
      default: grant = GRANT_NONE;
    endcase
  end

  assign sel  = sel_q;
  assign busy = |grant;

endmodule

// File: tb/tb_rr_arb2_sel.sv
// Randomised and directed bench for rr_arb2_sel at MAX_HOLD=4 and MAX_HOLD=1,
// checked against an owner/count/pointer model of the arbitration rules.
module tb_rr_arb2_sel;

  typedef struct {
    int owner;  // -1 idle, else index of granted source
    int cnt;
    int ptr;
    int sel;
  } m_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;

  logic [1:0] grant4, grant1;
  logic       sel4, sel1, busy4, busy1;
  logic [2:0] hcnt4;
  logic [0:0] hcnt1;

  int n_chk;
  int n_fail;
  m_t m4, m1;

  rr_arb2_sel #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant4), .sel(sel4), .busy(busy4), .hold_cnt(hcnt4)
  );

  rr_arb2_sel #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant1), .sel(sel1), .busy(busy1), .hold_cnt(hcnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic m_t m_reset();
    m_t m;
    m.owner = -1; m.cnt = 0; m.ptr = 0; m.sel = 0;
    return m;
  endfunction

  function automatic m_t m_step(m_t m, logic [1:0] r, int maxh);
    m_t n;
    int want;
    int other;
    n = m;
    if (m.owner < 0) begin
      if (r == 2'b00)      want = -1;
      else if (r == 2'b01) want = 0;
      else if (r == 2'b10) want = 1;
      else                 want = m.ptr;
    end else begin
      other = 1 - m.owner;
      if (!r[m.owner])                          want = r[other] ? other : -1;
      else if (r[other] && m.cnt == maxh - 1)   want = other;
      else                                      want = m.owner;
    end
    if (m.owner >= 0 && want != m.owner) n.ptr = 1 - m.owner;
    if (want != m.owner)                 n.cnt = 0;
    else if (want >= 0 && m.cnt < maxh)  n.cnt = m.cnt + 1;
    n.owner = want;
    if (want >= 0) n.sel = want;
    return n;
  endfunction

  function automatic int enc(int owner);
    return (owner < 0) ? 0 : (1 << owner);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("g4",      int'(grant4), enc(m4.owner));
    chk("sel4",    int'(sel4),   m4.sel);
    chk("busy4",   int'(busy4),  (m4.owner >= 0) ? 1 : 0);
    chk("cnt4",    int'(hcnt4),  m4.cnt);
    chk("g4_not11", (grant4 == 2'b11) ? 1 : 0, 0);
    chk("g1",      int'(grant1), enc(m1.owner));
    chk("sel1",    int'(sel1),   m1.sel);
    chk("busy1",   int'(busy1),  (m1.owner >= 0) ? 1 : 0);
    chk("cnt1",    int'(hcnt1),  m1.cnt);
    chk("g1_not11", (grant1 == 2'b11) ? 1 : 0, 0);
  endtask

  // One clock: model advances on the edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m4 = m_reset();
      m1 = m_reset();
    end else begin
      m4 = m_step(m4, req, 4);
      m1 = m_step(m1, req, 1);
    end
    @(negedge clk);
    compare();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    m4 = m_reset();
    m1 = m_reset();
    compare();
    @(negedge clk);
    compare();
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    req    = 2'b11;
    m4 = m_reset();
    m1 = m_reset();

    for (int k = 0; k < 3; k++) tick();
    chk("rst_grant", int'(grant4), 0);
    chk("rst_sel",   int'(sel4),   0);
    chk("rst_busy",  int'(busy4),  0);
    chk("rst_cnt",   int'(hcnt4),  0);
    rst_n = 1'b1;

    req = 2'b10;
    tick();
    chk("single_grant", int'(grant4), 2);
    chk("single_sel",   int'(sel4),   1);
    chk("single_busy",  int'(busy4),  1);
    for (int k = 0; k < 10; k++) tick();
    chk("single_hold_grant", int'(grant4), 2);
    chk("single_hold_sat",   int'(hcnt4),  4);
    req = 2'b00;
    tick();
    chk("idle_grant", int'(grant4), 0);
    chk("idle_sel",   int'(sel4),   1);

    reset_pulse();
    req = 2'b11;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("burst4", int'(grant4), (k < 4 || k >= 8) ? 1 : 2);
      if (k < 6) chk("alt1", int'(grant1), (k % 2 == 0) ? 1 : 2);
    end

    reset_pulse();
    req = 2'b11;
    tick();
    tick();
    chk("early_cnt", int'(hcnt4), 1);
    req = 2'b10;
    tick();
    chk("early_grant", int'(grant4), 2);
    chk("early_cnt0",  int'(hcnt4),  0);

    req = 2'b10; tick(); tick();
    req = 2'b00; tick(); tick();
    req = 2'b11; tick();
    chk("ptr_after_g1", int'(grant4), 1);
    req = 2'b01; tick(); tick();
    req = 2'b00; tick(); tick();
    req = 2'b11; tick();
    chk("ptr_after_g0", int'(grant4), 2);

    tick();
    async_reset();
    chk("async_grant", int'(grant4), 0);
    chk("async_busy",  int'(busy4),  0);
    req = 2'b11;
    tick();
    chk("post_rst_grant", int'(grant4), 1);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1) == 0) req = 2'b11;
      else                           req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) async_reset();
      else                             tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
